fwd_hazard_unit: RTL and testbench

Parametrised forwarding and load-use hazard unit for the pipelined CPU, sitting beside the EX stage ALU operand muxes. It tracks the in-flight destination registers of up to FWD_DEPTH downstream stages and drives one operand-select per ALU source. It detects load-use hazards one stage early, asserts a decode stall, and injects a bubble into EX. This replaces pure combinational EX/MEM and MEM/WB comparison with a self-contained tracking pipeline.

---
 rtl/fwd_hazard_unit.sv | 147 ++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall unit beside the EX-stage ALU operand muxes.
// Define FWD_STALL_CNT_EN to build the saturating 16-bit stall counter; otherwise stall_cnt is tied to zero.
module fwd_hazard_unit #(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic              flush,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rs,
  input  logic [REG_AW-1:0] dec_rt,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_regwrite,
  input  logic              dec_memread,
  output logic [SEL_W-1:0]  fwd_sel_a,
  output logic [SEL_W-1:0]  fwd_sel_b,
  output logic              stall,
  output logic [15:0]       stall_cnt
);

  logic              exValid_p0;
  logic [REG_AW-1:0] exRs_p0;
  logic [REG_AW-1:0] exRt_p0;
  logic [REG_AW-1:0] exRd_p0;
  logic              exRegwrite_p0;
  logic              exMemread_p0;

  logic [FWD_DEPTH-1:0]             dstValid_p1;
  logic [FWD_DEPTH-1:0][REG_AW-1:0] dstRd_p1;

  logic loadUse;
  logic lateHaz;
  logic lateHold;

  // Lowest matching stage index is the youngest producer, so it must win.
  function automatic logic [SEL_W-1:0] fwdSelect(
    input logic [REG_AW-1:0]              src,
    input logic [FWD_DEPTH-1:0]             vld,
    input logic [FWD_DEPTH-1:0][REG_AW-1:0] rd
  );
    logic [SEL_W-1:0] sel;
    sel = '0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (vld[k] && (rd[k] == src) && (src != '0)) sel = SEL_W'(k + 1);
    end
    return sel;
  endfunction

  function automatic logic [15:0] satInc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  assign loadUse = dec_valid && exValid_p0 && exRegwrite_p0 && exMemread_p0 &&
                   (exRd_p0 != '0) && ((exRd_p0 == dec_rs) || (exRd_p0 == dec_rt));

  // With a single tracked stage the loaded value is not forwardable from dst[0],
  // so the EX instruction waits in place until the load leaves the window.
  generate
    if (FWD_DEPTH == 1) begin : gLateLoad
      logic dst0Memread_p1;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dst0Memread_p1 <= 1'b0;
        end else if (adv) begin
          dst0Memread_p1 <= lateHold ? 1'b0 : exMemread_p0;
        end
      end

      assign lateHaz = exValid_p0 && dstValid_p1[0] && dst0Memread_p1 &&
                       (dstRd_p1[0] != '0) &&
                       ((dstRd_p1[0] == exRs_p0) || (dstRd_p1[0] == exRt_p0));
    end else begin : gNoLateLoad
      assign lateHaz = 1'b0;
    end
  endgenerate

  assign lateHold = lateHaz && !flush;
  assign stall    = (loadUse || lateHaz) && !flush;

  assign fwd_sel_a = exValid_p0 ? fwdSelect(exRs_p0, dstValid_p1, dstRd_p1) : '0;
  assign fwd_sel_b = exValid_p0 ? fwdSelect(exRt_p0, dstValid_p1, dstRd_p1) : '0;

  // Stage p0: EX slot; stage p1: downstream destination tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exValid_p0    <= 1'b0;
      exRs_p0       <= '0;
      exRt_p0       <= '0;
      exRd_p0       <= '0;
      exRegwrite_p0 <= 1'b0;
      exMemread_p0  <= 1'b0;
      dstValid_p1   <= '0;
      dstRd_p1      <= '0;
    end else if (adv) begin
      for (int i = FWD_DEPTH - 1; i >= 1; i--) begin
        dstValid_p1[i] <= dstValid_p1[i-1];
        dstRd_p1[i]    <= dstRd_p1[i-1];
      end
      if (lateHold) begin
        dstValid_p1[0] <= 1'b0;
        dstRd_p1[0]    <= '0;
      end else begin
        dstValid_p1[0] <= exValid_p0 && exRegwrite_p0;
        dstRd_p1[0]    <= exRd_p0;
      end

      if (!lateHold) begin
        if (stall || flush) begin
          exValid_p0    <= 1'b0;
          exRs_p0       <= '0;
          exRt_p0       <= '0;
          exRd_p0       <= '0;
          exRegwrite_p0 <= 1'b0;
          exMemread_p0  <= 1'b0;
        end else begin
          exValid_p0    <= dec_valid;
          exRs_p0       <= dec_rs;
          exRt_p0       <= dec_rt;
          exRd_p0       <= dec_rd;
          exRegwrite_p0 <= dec_regwrite;
          exMemread_p0  <= dec_memread;
        end
      end
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [15:0] stallCnt_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt_p1 <= 16'h0000;
    end else if (stall && adv) begin
      stallCnt_p1 <= satInc16(stallCnt_p1);
    end
  end

  assign stall_cnt = stallCnt_p1;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: driver queues hand-computed expectations, monitor checks them.
module tb_fwd_hazard_unit;
  localparam int REG_AW    = 5;
  localparam int FWD_DEPTH = 2;
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              adv;
  logic              flush;
  logic              dec_valid;
  logic [REG_AW-1:0] dec_rs;
  logic [REG_AW-1:0] dec_rt;
  logic [REG_AW-1:0] dec_rd;
  logic              dec_regwrite;
  logic              dec_memread;
  logic [SEL_W-1:0]  fwd_sel_a;
  logic [SEL_W-1:0]  fwd_sel_b;
  logic              stall;
  logic [15:0]       stall_cnt;

  typedef struct {
    string name;
    int    selA;
    int    selB;
    int    stl;
    int    cnt;
  } exp_t;

  exp_t sbQ[$];
  int   total  = 0;
  int   bad    = 0;
  int   expCnt = 0;

  fwd_hazard_unit #(.REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .adv(adv), .flush(flush),
    .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd),
    .dec_regwrite(dec_regwrite), .dec_memread(dec_memread),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic pushExp(input string nm, input int eA, input int eB, input int eS);
    exp_t e;
    e.name = nm;
    e.selA = eA;
    e.selB = eB;
    e.stl  = eS;
    e.cnt  = expCnt;
    sbQ.push_back(e);
  endtask

  task automatic cyc(input string nm, input bit v, input int rs, input int rt, input int rd,
                     input bit rw, input bit mr, input bit a, input bit fl,
                     input int eA, input int eB, input int eS);
    dec_valid    = v;
    dec_rs       = REG_AW'(rs);
    dec_rt       = REG_AW'(rt);
    dec_rd       = REG_AW'(rd);
    dec_regwrite = rw;
    dec_memread  = mr;
    adv          = a;
    flush        = fl;
    pushExp(nm, eA, eB, eS);
    @(posedge clk);
    #1;
`ifdef FWD_STALL_CNT_EN
    if (eS != 0 && a && expCnt < 65535) expCnt++;
`endif
  endtask

  // Monitor: outputs are sampled 1 time unit after a falling clock or reset edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      while (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        total++;
        if (fwd_sel_a !== SEL_W'(e.selA) || fwd_sel_b !== SEL_W'(e.selB) ||
            stall !== (e.stl != 0) || stall_cnt !== 16'(e.cnt)) begin
          bad++;
          $display("FAIL %s: got a=%0d b=%0d stall=%0b cnt=%0d, want a=%0d b=%0d stall=%0d cnt=%0d",
                   e.name, fwd_sel_a, fwd_sel_b, stall, stall_cnt, e.selA, e.selB, e.stl, e.cnt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; adv = 1'b1; flush = 1'b0; dec_valid = 1'b0;
    dec_rs = '0; dec_rt = '0; dec_rd = '0; dec_regwrite = 1'b0; dec_memread = 1'b0;
    pushExp("reset", 0, 0, 0);
    @(negedge clk); #2;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Back-to-back ALU dependency
    cyc("c1_add",          1, 1, 2, 3, 1, 0, 1, 0, 0, 0, 0);
    cyc("c2_sub",          1, 3, 4, 5, 1, 0, 1, 0, 0, 0, 0);
    cyc("c3_fwd_exmem",    0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    // Double match: youngest wins, then only dst[1]
    cyc("c4",              1, 1, 0, 3, 1, 0, 1, 0, 0, 0, 0);
    cyc("c5",              1, 2, 0, 3, 1, 0, 1, 0, 0, 0, 0);
    cyc("c6",              1, 3, 6, 7, 1, 0, 1, 0, 0, 0, 0);
    cyc("c7_dbl_youngest", 1, 3, 7, 8, 1, 0, 1, 0, 1, 0, 0);
    cyc("c8_sel2_sel1",    0, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0);
    // Load-use
    cyc("c9_lw",           1, 1, 0, 7, 1, 1, 1, 0, 0, 0, 0);
    cyc("c10_loaduse",     1, 2, 7, 9, 1, 0, 1, 0, 0, 0, 1);
    cyc("c11_bubble",      1, 2, 7, 9, 1, 0, 1, 0, 0, 0, 0);
    cyc("c12_fwd_load",    0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0);
    // Register 0
    cyc("c13_write_r0",    1, 1, 2, 0, 1, 0, 1, 0, 0, 0, 0);
    cyc("c14",             1, 0, 0, 4, 1, 0, 1, 0, 0, 0, 0);
    cyc("c15_r0_nofwd",    1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    cyc("c16_lw_r0_nostl", 1, 0, 5, 6, 1, 0, 1, 0, 0, 0, 0);
    cyc("c17",             0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Freeze during stall
    cyc("c18_lw10",        1, 1, 0, 10, 1, 1, 1, 0, 0, 0, 0);
    cyc("c19_freeze",      1, 10, 2, 11, 1, 0, 0, 0, 0, 0, 1);
    cyc("c20_freeze",      1, 10, 2, 11, 1, 0, 0, 0, 0, 0, 1);
    cyc("c21_freeze",      1, 10, 2, 11, 1, 0, 0, 0, 0, 0, 1);
    cyc("c22_stall_adv",   1, 10, 2, 11, 1, 0, 1, 0, 0, 0, 1);
    cyc("c23_bubble",      1, 10, 2, 11, 1, 0, 1, 0, 0, 0, 0);
    cyc("c24_fwd_load",    0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0);
    // Flush over stall
    cyc("c25_lw12",        1, 1, 0, 12, 1, 1, 1, 0, 0, 0, 0);
    cyc("c26_flush",       1, 12, 12, 13, 1, 0, 1, 1, 0, 0, 0);
    cyc("c27_no_fwd",      1, 12, 0, 14, 1, 0, 1, 0, 0, 0, 0);
    cyc("c28",             1, 14, 12, 15, 1, 0, 1, 0, 2, 0, 0);
    cyc("c29",             1, 0, 0, 16, 1, 1, 1, 0, 1, 0, 0);

    // Reset asserted mid-stall with tracking stages populated
    dec_valid = 1'b1; dec_rs = 5'd16; dec_rt = 5'd15; dec_rd = 5'd17;
    dec_regwrite = 1'b1; dec_memread = 1'b0; adv = 1'b1; flush = 1'b0;
    pushExp("c30_stall", 0, 0, 1);
    @(negedge clk); #2;
    rst_n  = 1'b0;
    expCnt = 0;
    pushExp("c30_async_rst", 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    cyc("c31_post_rst",    1, 16, 15, 17, 1, 0, 1, 0, 0, 0, 0);
    cyc("c32_first_instr", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    @(negedge clk); #3;
    total++;
    if (sbQ.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", sbQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
